music_transport_controller: RTL and testbench

//  Transport/timing controller for the PWM music channels. Derives the frame tick
//  (i_tick_stb) and note-step strobe (i_note_stb) consumed by each channel note

---
 rtl/music_transport_controller.sv | 180 ++++++++++++++++++
 tb/tb_music_transport_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/music_transport_controller.sv
// Transport/timing controller for the PWM music channels: derives the frame tick and
// note-step strobes, runs STOPPED/PLAYING/PAUSED, and applies a run-time tempo.
module music_transport_controller #(
    parameter int TICK_DIV     = 416_666,
    parameter int DEF_TPN      = 6,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_play,
    input  logic                    i_pause,
    input  logic                    i_stop,
    input  logic [3:0]              i_tempo,
    input  logic                    i_tempo_load,
    input  logic [NUM_CHANNELS-1:0] i_chan_mask,
    output logic                    o_tick_stb,
    output logic                    o_note_stb,
    output logic [NUM_CHANNELS-1:0] o_chan_tick_stb,
    output logic [NUM_CHANNELS-1:0] o_chan_note_stb,
    output logic                    o_restart,
    output logic [1:0]              o_state,
    output logic [15:0]             o_frame_count
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
    localparam logic [3:0]       TPN_RST  = 4'(DEF_TPN);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    // A tempo of zero would never complete a step, so it is promoted to one tick.
    function automatic logic [3:0] norm_tempo(input logic [3:0] tempo);
        logic [3:0] res;
        if (tempo == 4'd0) begin
            res = 4'd1;
        end else begin
            res = tempo;
        end
        return res;
    endfunction

    state_t                  state_r;
    logic [DIV_W-1:0]        div_r;
    logic [3:0]              note_cnt_r;
    logic [3:0]              tpn_r;
    logic [3:0]              pend_tpn_r;
    logic                    pend_valid_r;
    logic [NUM_CHANNELS-1:0] mask_r;
    logic [15:0]             frame_r;
    logic                    tick_r;
    logic                    note_r;
    logic [NUM_CHANNELS-1:0] chan_tick_r;
    logic [NUM_CHANNELS-1:0] chan_note_r;
    logic                    restart_r;

    logic                    play_s;
    logic                    advance_s;
    logic                    tick_s;
    logic                    note_s;
    logic [3:0]              tempo_s;
    logic [3:0]              tpn_next_s;
    logic [3:0]              pend_next_s;
    logic                    pend_valid_next_s;

    // Command decode (stop > pause > play), strobe conditions and tempo hand-over.
    always_comb begin
        play_s            = i_play & ~i_pause & ~i_stop;
        advance_s         = (state_r == ST_PLAYING) & ~i_pause & ~i_stop;
        tick_s            = advance_s & (div_r == DIV_LAST);
        note_s            = tick_s & (note_cnt_r >= (tpn_r - 4'd1));
        tempo_s           = norm_tempo(i_tempo);
        tpn_next_s        = tpn_r;
        pend_next_s       = pend_tpn_r;
        pend_valid_next_s = pend_valid_r;
        // New tempo only takes over at a step boundary so the running step keeps its length.
        if (i_tempo_load) begin
            pend_next_s = tempo_s;
            if ((state_r == ST_STOPPED) || note_s || i_stop) begin
                tpn_next_s        = tempo_s;
                pend_valid_next_s = 1'b0;
            end else begin
                pend_valid_next_s = 1'b1;
            end
        end else if (pend_valid_r && (note_s || i_stop)) begin
            tpn_next_s        = pend_tpn_r;
            pend_valid_next_s = 1'b0;
        end else begin
            tpn_next_s        = tpn_r;
            pend_valid_next_s = pend_valid_r;
        end
    end

    // Transport state machine, counters and registered strobe outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_STOPPED;
            div_r        <= {DIV_W{1'b0}};
            note_cnt_r   <= 4'd0;
            tpn_r        <= TPN_RST;
            pend_tpn_r   <= TPN_RST;
            pend_valid_r <= 1'b0;
            mask_r       <= {NUM_CHANNELS{1'b0}};
            frame_r      <= 16'd0;
            tick_r       <= 1'b0;
            note_r       <= 1'b0;
            chan_tick_r  <= {NUM_CHANNELS{1'b0}};
            chan_note_r  <= {NUM_CHANNELS{1'b0}};
            restart_r    <= 1'b0;
        end else begin
            mask_r       <= i_chan_mask;
            tpn_r        <= tpn_next_s;
            pend_tpn_r   <= pend_next_s;
            pend_valid_r <= pend_valid_next_s;
            tick_r       <= tick_s;
            note_r       <= note_s;
            chan_tick_r  <= tick_s ? mask_r : {NUM_CHANNELS{1'b0}};
            chan_note_r  <= note_s ? mask_r : {NUM_CHANNELS{1'b0}};
            restart_r    <= 1'b0;
            case (state_r)
                ST_STOPPED: begin
                    if (play_s) begin
                        state_r    <= ST_PLAYING;
                        restart_r  <= 1'b1;
                        div_r      <= {DIV_W{1'b0}};
                        note_cnt_r <= 4'd0;
                        frame_r    <= 16'd0;
                    end else begin
                        state_r    <= ST_STOPPED;
                    end
                end
                ST_PLAYING: begin
                    if (i_stop) begin
                        state_r    <= ST_STOPPED;
                        div_r      <= {DIV_W{1'b0}};
                        note_cnt_r <= 4'd0;
                    end else if (i_pause) begin
                        state_r    <= ST_PAUSED;
                    end else if (tick_s) begin
                        div_r      <= {DIV_W{1'b0}};
                        frame_r    <= frame_r + 16'd1;
                        note_cnt_r <= note_s ? 4'd0 : (note_cnt_r + 4'd1);
                    end else begin
                        div_r      <= div_r + DIV_ONE;
                    end
                end
                ST_PAUSED: begin
                    // Counters stay frozen; resuming picks up the divider where it stopped.
                    if (i_stop) begin
                        state_r    <= ST_STOPPED;
                        div_r      <= {DIV_W{1'b0}};
                        note_cnt_r <= 4'd0;
                    end else if (play_s) begin
                        state_r    <= ST_PLAYING;
                    end else begin
                        state_r    <= ST_PAUSED;
                    end
                end
                default: begin
                    state_r    <= ST_STOPPED;
                    div_r      <= {DIV_W{1'b0}};
                    note_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign o_tick_stb      = tick_r;
    assign o_note_stb      = note_r;
    assign o_chan_tick_stb = chan_tick_r;
    assign o_chan_note_stb = chan_note_r;
    assign o_restart       = restart_r;
    assign o_state         = state_r;
    assign o_frame_count   = frame_r;

endmodule

// File: tb/tb_music_transport_controller.sv
// Directed bench for music_transport_controller: expected strobe events are queued as
// commands are driven and compared against the outputs every cycle.
module tb_music_transport_controller;

    localparam int TICK_DIV = 4;
    localparam int DEF_TPN  = 3;
    localparam int NCH      = 4;

    logic           clk;
    logic           rst_n;
    logic           play;
    logic           pause;
    logic           stop;
    logic [3:0]     tempo;
    logic           tempo_load;
    logic [NCH-1:0] chan_mask;
    logic           tick_stb;
    logic           note_stb;
    logic [NCH-1:0] chan_tick_stb;
    logic [NCH-1:0] chan_note_stb;
    logic           restart;
    logic [1:0]     state;
    logic [15:0]    frame_count;

    typedef struct {
        int             at;
        logic           restart;
        logic           tick;
        logic           note;
        logic [NCH-1:0] mask;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [10:0] exp_vec;

    music_transport_controller #(
        .TICK_DIV    (TICK_DIV),
        .DEF_TPN     (DEF_TPN),
        .NUM_CHANNELS(NCH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_play         (play),
        .i_pause        (pause),
        .i_stop         (stop),
        .i_tempo        (tempo),
        .i_tempo_load   (tempo_load),
        .i_chan_mask    (chan_mask),
        .o_tick_stb     (tick_stb),
        .o_note_stb     (note_stb),
        .o_chan_tick_stb(chan_tick_stb),
        .o_chan_note_stb(chan_note_stb),
        .o_restart      (restart),
        .o_state        (state),
        .o_frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_ev(input int at, input logic r, input logic t, input logic n);
        ev_t e;
        e.at      = at;
        e.restart = r;
        e.tick    = t;
        e.note    = n;
        e.mask    = chan_mask;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        ev_t e;
        exp_vec = 11'd0;
        if (sb.size() > 0) begin
            if (sb[0].at == cyc) begin
                e = sb.pop_front();
                exp_vec = {e.restart, e.tick, e.note,
                           e.tick ? e.mask : 4'd0, e.note ? e.mask : 4'd0};
            end
        end
        chk("strobes", {21'd0, restart, tick_stb, note_stb, chan_tick_stb, chan_note_stb},
            {21'd0, exp_vec});
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_en) sb_check();
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            step();
            guard++;
        end
        if (cyc < n) chk("wait_bound", cyc, n);
    endtask

    task automatic pulse(input logic pl, input logic pa, input logic st,
                         input logic ld, input logic [3:0] tv);
        play = pl; pause = pa; stop = st; tempo_load = ld; tempo = tv;
        step();
        play = 1'b0; pause = 1'b0; stop = 1'b0; tempo_load = 1'b0;
    endtask

    initial begin
        int c, p, d, e, f, g;
        rst_n = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
        tempo = 4'd0; tempo_load = 1'b0; chan_mask = 4'b1111;
        #1 rst_n = 1'b0;
        #22 rst_n = 1'b1;

        // reset and idle
        wait_cyc(5);
        mon_en = 1'b1;
        wait_cyc(55);
        chk("rst_state", state, 2'd0);
        chk("rst_frame", frame_count, 16'd0);

        // play: restart, ticks every TICK_DIV, note every third tick
        c = cyc;
        push_ev(c + 1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) push_ev(c + 1 + 4 * k, 1'b0, 1'b1, k == 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("play_state", state, 2'd1);
        wait_cyc(c + 14);
        chk("frame_3", frame_count, 16'd3);

        // pause one cycle after tick 5 (divider at 1), hold, resume
        wait_cyc(c + 22);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        wait_cyc(c + 30);
        chk("paused_state", state, 2'd2);
        chk("paused_frame", frame_count, 16'd5);
        wait_cyc(c + 43);
        chk("paused_frame_hold", frame_count, 16'd5);
        p = cyc;
        push_ev(p + 4, 1'b0, 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("resume_state", state, 2'd1);
        wait_cyc(p + 5);
        chk("resume_frame", frame_count, 16'd6);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_cyc(p + 7);
        chk("stop_state", state, 2'd0);
        wait_cyc(p + 12);
        chk("stop_frame_hold", frame_count, 16'd6);

        // tempo change mid-step: 3 -> 2 after tick 3, then 2 -> 1 after tick 11
        d = cyc;
        push_ev(d + 1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++)
            push_ev(d + 1 + 4 * k, 1'b0, 1'b1,
                    (k == 3) || (k > 3 && k <= 11 && (k % 2) == 1) || (k > 11));
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(d + 6);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        wait_cyc(d + 38);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        wait_cyc(d + 54);
        chk("tempo_frame", frame_count, 16'd13);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // channel mask 0101, immediate tempo load while stopped, stop beats play
        wait_cyc(d + 57);
        chan_mask = 4'b0101;
        step();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        wait_cyc(d + 60);
        e = cyc;
        push_ev(e + 1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) push_ev(e + 1 + 4 * k, 1'b0, 1'b1, k == 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(e + 14);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_cyc(e + 16);
        chk("stop_play_state", state, 2'd0);
        wait_cyc(e + 18);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_cyc(e + 20);
        chk("stop_play_idle_state", state, 2'd0);
        chk("stop_play_idle_frame", frame_count, 16'd3);

        // asynchronous reset while a tick strobe is high
        wait_cyc(e + 25);
        f = cyc;
        push_ev(f + 1, 1'b1, 1'b0, 1'b0);
        push_ev(f + 5, 1'b0, 1'b1, 1'b0);
        push_ev(f + 9, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(f + 9);
        chk("pre_rst_tick", tick_stb, 1'b1);
        chk("pre_rst_state", state, 2'd1);
        chk("pre_rst_frame", frame_count, 16'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tick", tick_stb, 1'b0);
        chk("async_chan_tick", chan_tick_stb, 4'd0);
        chk("async_state", state, 2'd0);
        chk("async_frame", frame_count, 16'd0);
        wait_cyc(f + 12);
        #2 rst_n = 1'b1;
        wait_cyc(f + 15);
        g = cyc;
        push_ev(g + 1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) push_ev(g + 1 + 4 * k, 1'b0, 1'b1, k == 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(g + 14);
        chk("post_rst_frame", frame_count, 16'd3);
        chk("post_rst_state", state, 2'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_cyc(g + 20);
        chk("final_state", state, 2'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
